// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and helpers for the sipo_deframer block.
//   state_t   - deframer FSM states (IDLE, COLLECT)
//   cnt_width - bit-counter width for a given word width
package sipo_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Counter only ever holds 0..WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: shift register and bit counter of the deframer.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   sbit    in   serial bit to store
//   bit_en  in   store sbit this cycle
//   restart in   sbit is bit 0 of a new word (partial contents dropped)
//   word    out  register contents with the current bit merged in; on the
//                completing cycle this is the finished word
//   cnt     out  index of the next bit to be stored
//   last    out  the next stored bit completes the word
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CW        = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sbit,
    input  logic             bit_en,
    input  logic             restart,
    output logic [WIDTH-1:0] word,
    output logic [CW-1:0]    cnt,
    output logic             last
);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] merged;
    logic [CW-1:0]    bit_idx;
    logic [CW-1:0]    pos;

    // NOTE: every combinational output gets a default before any conditional
    // update, so no path leaves a value held and no latch is inferred.
    always_comb begin
        bit_idx = restart ? '0 : cnt;
        pos     = LSB_FIRST ? bit_idx : CW'(WIDTH - 1) - bit_idx;
        merged  = restart ? '0 : shreg;
        merged[pos] = sbit;
    end

    assign word = merged;
    assign last = (cnt == CW'(WIDTH - 1));

    // NOTE: state registers use non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (bit_en) begin
            shreg <= merged;
            if (restart)
                cnt <= CW'(1);
            else if (last)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// sipo_deframer: reassembles a start-aligned serial bit stream into
// WIDTH-bit words held in a one-entry valid/ready output register.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   sin        in   serial data bit, qualified by sin_valid
//   sin_valid  in   sin carries a bit this cycle
//   sin_start  in   the current valid bit is bit 0 of a new word
//   pout       out  assembled word, stable while pout_valid=1
//   pout_valid out  output register holds an unconsumed word
//   pout_ready in   consumer takes pout when pout_valid & pout_ready
//   frame_err  out  one-cycle pulse: partial word discarded by a new start
//   overrun    out  one-cycle pulse: completed word dropped, output full
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_next;
    logic             bit_en;
    logic             complete;
    logic             frame_err_next;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt;
    logic             last;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .CW        (CW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .sbit    (sin),
        .bit_en  (bit_en),
        .restart (sin_start),
        .word    (word),
        .cnt     (cnt),
        .last    (last)
    );

    // In IDLE only a start bit is accepted; stray bits are dropped silently.
    always_comb begin
        state_next     = state;
        bit_en         = 1'b0;
        complete       = 1'b0;
        frame_err_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (sin_valid && sin_start) begin
                    bit_en     = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (sin_valid) begin
                    bit_en = 1'b1;
                    if (sin_start) begin
                        // A partial word is being thrown away.
                        frame_err_next = (cnt != '0);
                    end else if (last) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the reset is synchronous, so it lives inside the clocked block
    // and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pout       <= '0;
            pout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= frame_err_next;
            overrun   <= 1'b0;
            if (complete) begin
                // A word leaving this same cycle frees the slot for the new one.
                if (!pout_valid || pout_ready) begin
                    pout       <= word;
                    pout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-in/parallel-out deframer that consumes the single-bit stream produced by the team's parallel-to-serial shift stage and reassembles it into WIDTH-bit words. A start strobe aligns each word, a bit counter tracks position, and completed words sit in a one-entry output register with a valid/ready handshake toward the parallel consumer. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1: first serial bit lands in pout[0]; 0: first serial bit lands in pout[WIDTH-1].
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- sin  in  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  in  1  qualifies sin this cycle.
- sin_start  in  1  marks the current valid bit as bit 0 of a new word; ignored when sin_valid=0.
- pout  out  WIDTH  assembled word; stable while pout_valid=1.
- pout_valid  out  1  output register holds an unconsumed word.
- pout_ready  in  1  consumer accepts pout when pout_valid & pout_ready.
- frame_err  out  1  one-cycle pulse: partial word discarded by a new start.
- overrun  out  1  one-cycle pulse: completed word dropped because the output was full.

## Operation
- FSM states: IDLE and COLLECT.
- IDLE:
  - A valid bit without sin_start is discarded silently.
  - A valid bit with sin_start is stored as bit 0, the counter is set to 1, and the FSM moves to COLLECT.
- COLLECT:
  - A valid bit without start is stored at position cnt, then cnt+1.
  - A valid bit with start discards the partial word and pulses frame_err next cycle. That bit is stored as bit 0, cnt=1, and the FSM stays in COLLECT.
  - A valid bit at cnt=WIDTH-1 completes the word and returns the FSM to IDLE.
- Bit placement:
  - LSB_FIRST=1: bit k goes to position k.
  - LSB_FIRST=0: bit k goes to position WIDTH-1-k.
- Completion transfer:
  - If pout_valid=0, or pout_valid & pout_ready in the same cycle, the word loads into pout and pout_valid=1.
  - Otherwise the new word is dropped, pout is unchanged, and overrun pulses.
- Drain: pout_valid & pout_ready with no completion clears pout_valid. pout keeps its last value.
- Counter width: clog2(WIDTH). Counting never wraps past WIDTH-1 because completion always returns the FSM to IDLE.
- Reset values: pout=0, pout_valid=0, frame_err=0, overrun=0, FSM=IDLE, cnt=0, shift register=0.

## Timing
- Latency: pout and pout_valid update on the clock edge that samples the last bit, so they are visible the cycle after that bit is presented.
- Throughput: one bit per cycle. Back-to-back words need no idle cycle: the start bit of word N+1 may directly follow the last bit of word N.
- frame_err and overrun are registered pulses of exactly one cycle, asserted the cycle after the causing input.
- Completion and drain in the same cycle: the new word loads, pout_valid stays 1, and no overrun is raised.
- sin_valid gaps of any length inside a word are allowed; cnt and partial data are held.
- rst mid-word or with pout_valid=1:
  - All state returns to reset values on that edge.
  - Any pending word is lost, and no frame_err or overrun is raised.
  - Inputs in the reset cycle are ignored.

## Structure
- Package sipo_pkg:
  - State typedef {IDLE, COLLECT}.
  - Count-width function clog2(WIDTH).
- Sub-module sipo_shift_core holds the shift register and bit counter, with LSB_FIRST placement.
  - Inputs: clk, rst, bit, bit_en, restart.
  - Outputs: word, cnt, last.
- Top level holds the FSM, the output register, the handshake, and the error pulses.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> pout=0, pout_valid=0, frame_err=0, overrun=0 throughout and one cycle after release.
- Basic word (WIDTH=4, LSB_FIRST=1, pout_ready=1):
  - Send bits 1,0,1,1 with start on the first bit -> pout=4'b1101, pout_valid=1 the cycle after the 4th bit.
  - Same stimulus with LSB_FIRST=0 -> pout=4'b1011.
- Back-pressure (pout_ready=0): send word A=4'h5 then word B=4'hA back-to-back.
  - pout stays 4'h5 and overrun pulses once after B's last bit.
  - Raising pout_ready drains A, then pout_valid=0.
- Simultaneous completion and drain: pout holds 4'h3 with pout_ready=1 on the cycle word 4'hC completes -> pout=4'hC, pout_valid=1, no overrun.
- Realignment:
  - Send two bits, then a new start followed by 1,1,0,0 -> frame_err pulses once and pout=4'b0011.
  - Valid bits with no start in IDLE produce no output.
- Gaps and reset:
  - Word 4'h9 sent with 2-cycle sin_valid gaps between bits -> pout=4'h9.
  - Assert rst after 2 bits of the next word -> all outputs clear; a subsequent word 4'h6 assembles correctly.
